sbi_burst_arbiter: RTL and testbench
====================================

Name: sbi_burst_arbiter

Overview:
Multi-requester master for the simple burst interface (SBI) bus. It arbitrates round-robin between NumReq burst requesters and sequences the SBI control signals: bSTART, then a run of bACCESS beats with bWRITE held stable. It forwards per-beat write data and routes returned read data (bQ/bVALID) to the owning requester. It sits between client engines and the single SBI memory port.

Parameters:
NumReq, 2, number of requesters (2..8)
Width, 32, data width, matches the SBI data width
Depth, 256, SBI address space; Aw = $clog2(Depth)
MaxLen, 16, max beats per burst (power of two); Lw = $clog2(MaxLen)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
req_i  in  NumReq  burst request per requester; level, held until gnt_o
we_i  in  NumReq  1 = write burst, 0 = read burst
addr_i  in  NumReq*Aw  start address per requester
len_i  in  NumReq*Lw  beats minus 1 (0 = 1 beat, MaxLen-1 = MaxLen beats)
wdata_i  in  NumReq*Width  write data per requester, show-ahead, consumed when wready_o is high
gnt_o  out  NumReq  one-cycle grant pulse; request fields latched this cycle
wready_o  out  NumReq  write beat taken this cycle
rdata_o  out  Width  read data, shared by all requesters
rvalid_o  out  NumReq  read beat valid for the owning requester
done_o  out  NumReq  one-cycle pulse at the last beat of the owner's burst
busy_o  out  1  state != IDLE
bADDR  out  Aw  SBI start address
bSTART  out  1  SBI burst start
bACCESS  out  1  SBI beat strobe
bWRITE  out  1  SBI direction
bD  out  Width  SBI write data
bQ  in  Width  SBI read data
bVALID  in  1  SBI read data valid

Behaviour:
- Reset is rst_ni, asynchronous, active-low. Clock is clk_i.
- All outputs reset to 0. The FSM resets to IDLE and the round-robin pointer resets to 0 (requester 0 has highest priority).
- FSM states: IDLE, START, BURST, DRAIN.
- IDLE:
  - When any req_i bit is high, pick the winner round-robin, starting the search at the pointer.
  - Latch owner, we, addr and len from the winner; pulse gnt_o[owner]; set the pointer to owner+1 (mod NumReq).
  - Next state: START.
  - With no request, stay in IDLE.
- START (1 cycle):
  - bSTART=1, bADDR=latched addr, bWRITE=latched we, bACCESS=0.
  - bSTART and bACCESS are never high in the same cycle, because the address is loaded one cycle before the first beat.
  - Next state: BURST with beat counter = 0.
- BURST (len+1 cycles):
  - bACCESS=1 and bWRITE is held every cycle.
  - Writes: wready_o[owner]=1 and bD=wdata_i[owner] each beat.
  - Last beat is when counter == len.
    - Write: pulse done_o[owner], next state IDLE.
    - Read: next state DRAIN.
- DRAIN (reads only, 1 cycle):
  - bACCESS=0, bWRITE held at 0. The final bVALID arrives in this cycle.
  - Pulse done_o[owner] together with the last rvalid_o, then go to IDLE.
- Read return path: rdata_o = bQ; rvalid_o[owner] = bVALID while in BURST or DRAIN and the latched we = 0, otherwise 0.
  - Read latency is fixed at 1 cycle after each bACCESS beat; beats arrive in order.
- bD is 0 when no write beat is active. bADDR holds its last value outside START.
- Throughput: write burst of L beats occupies L+1 cycles plus 1 IDLE cycle; read burst occupies L+2 cycles plus 1 IDLE cycle.
- Boundary conditions:
  - Lowering req_i after the grant has no effect; the burst always completes.
  - A requester that keeps req_i high is granted again only after every other pending requester has been served.
  - Address wrap at Depth is handled by the SBI slave (modulo Depth); the arbiter does not check it.
  - len_i = MaxLen-1: the counter reaches MaxLen-1 without overflow (Lw bits).
  - Reset mid-burst: bACCESS/bSTART drop immediately and rvalid_o/done_o are suppressed. A truncated burst is not replayed.
  - bVALID outside BURST/DRAIN, or during a write burst, is ignored.

Decomposition:
- sbi_pkg holds the state enum (IDLE/START/BURST/DRAIN) and the localparam helper for Lw.
- One sub-module, sbi_rr_arbiter: NumReq request vector plus pointer in, one-hot grant plus index out. It is combinational and handles pointer rotation including wrap past NumReq-1.
- The FSM, latches and datapath muxes stay in sbi_burst_arbiter.

Test Plan:
- Single write: req_i[0] with addr=0x10, len=3, wdata 0xA0..0xA3.
  - Expect gnt_o[0] at t0, bSTART with bADDR=0x10 at t1, bACCESS at t2..t5 with bD=0xA0..0xA3, and done_o[0] at t5.
- Single read: req_i[1] with addr=0x10, len=3, against a memory model.
  - Expect rvalid_o[1] at t3..t6 with data 0xA0..0xA3, done_o[1] at t6 (DRAIN), busy_o low at t7.
- Contention: req_i=2'b11 held for 4 bursts.
  - Expect grant order 0,1,0,1 with no bSTART/bACCESS overlap.
- Wrap: addr=0xFE, len=3 write, then read back from 0xFE.
  - Expect memory locations 0xFE, 0xFF, 0x00, 0x01 written, and the read returns the same 4 words.
- Max length: len=MaxLen-1 (16 beats).
  - Expect exactly 16 bACCESS cycles and the counter not wrapping early.
- Reset mid-burst: assert rst_ni low at the 2nd beat of an 8-beat read.
  - Expect all outputs 0 asynchronously, IDLE after release, and the next request granted to requester 0.

Source files
------------

// File: rtl/sbi_pkg.sv
// Package for the SBI burst arbiter.
// Holds the master FSM state encoding and a width helper that sizes counters,
// indices and addresses from the block parameters.
package sbi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StBurst = 2'd2,
        StDrain = 2'd3
    } sbi_state_e;

    // Bits needed to index n items. Never returns less than 1, so that
    // degenerate parameters still give legal vector widths.
    function automatic int unsigned sbi_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbi_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_i starting at index ptr_i and wrapping past NumReq-1. The first
// requester found wins.
// Ports:
//   req_i   - request vector
//   ptr_i   - index with the highest priority this cycle
//   gnt_o   - one-hot grant (all zero if no request)
//   idx_o   - index of the granted requester
//   valid_o - at least one request is pending
module sbi_rr_arbiter
    import sbi_pkg::*;
#(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned Iw     = sbi_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [Iw-1:0]     ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [Iw-1:0]     idx_o,
    output logic              valid_o
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            // Rotate the search window so that ptr_i is tried first.
            cand = 32'(ptr_i) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[Iw-1:0];
            end
        end
    end

endmodule

// File: rtl/sbi_burst_arbiter.sv
// Multi-requester master for the simple burst interface (SBI).
// Arbitrates round-robin between NumReq burst requesters, then sequences one
// bSTART cycle followed by len+1 bACCESS beats. Write data is forwarded from
// the owner; read data returns one cycle after each beat and is steered to the
// owner, with a single DRAIN cycle to collect the final read beat.
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   req_i/we_i        - per-requester burst request and direction
//   addr_i/len_i      - per-requester start address and beats-minus-one
//   wdata_i           - per-requester show-ahead write data
//   gnt_o             - one-cycle grant pulse
//   wready_o          - write beat consumed this cycle
//   rdata_o/rvalid_o  - shared read data, per-requester valid
//   done_o            - pulse at the last beat of the owner's burst
//   busy_o            - FSM not idle
//   bADDR..bD, bQ, bVALID - SBI memory port
module sbi_burst_arbiter
    import sbi_pkg::*;
#(
    parameter  int unsigned NumReq = 2,
    parameter  int unsigned Width  = 32,
    parameter  int unsigned Depth  = 256,
    parameter  int unsigned MaxLen = 16,
    localparam int unsigned Aw     = sbi_width(Depth),
    localparam int unsigned Lw     = sbi_width(MaxLen)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        we_i,
    input  logic [NumReq*Aw-1:0]     addr_i,
    input  logic [NumReq*Lw-1:0]     len_i,
    input  logic [NumReq*Width-1:0]  wdata_i,
    output logic [NumReq-1:0]        gnt_o,
    output logic [NumReq-1:0]        wready_o,
    output logic [Width-1:0]         rdata_o,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [NumReq-1:0]        done_o,
    output logic                     busy_o,
    output logic [Aw-1:0]            bADDR,
    output logic                     bSTART,
    output logic                     bACCESS,
    output logic                     bWRITE,
    output logic [Width-1:0]         bD,
    input  logic [Width-1:0]         bQ,
    input  logic                     bVALID
);

    localparam int unsigned Iw = sbi_width(NumReq);

    sbi_state_e      state_q, state_d;
    logic [Iw-1:0]   ptr_q, ptr_d;
    logic [Iw-1:0]   owner_q, owner_d;
    logic            we_q, we_d;
    logic [Aw-1:0]   addr_q, addr_d;
    logic [Lw-1:0]   len_q, len_d;
    logic [Lw-1:0]   cnt_q, cnt_d;

    logic [NumReq-1:0] arb_gnt;
    logic [Iw-1:0]     arb_idx;
    logic              arb_valid;
    logic              last_beat;

    sbi_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign last_beat = (cnt_q == len_q);
    assign busy_o    = (state_q != StIdle);
    // The address register is only reloaded on a grant, so bADDR holds its
    // last value outside START without extra muxing.
    assign bADDR     = addr_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gnt_o    = '0;
        wready_o = '0;
        done_o   = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        bSTART   = 1'b0;
        bACCESS  = 1'b0;
        bWRITE   = 1'b0;
        bD       = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_o   = arb_gnt;
                    owner_d = arb_idx;
                    we_d    = we_i[arb_idx];
                    addr_d  = addr_i[arb_idx*Aw +: Aw];
                    len_d   = len_i[arb_idx*Lw +: Lw];
                    ptr_d   = (arb_idx == Iw'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                bSTART  = 1'b1;
                bWRITE  = we_q;
                cnt_d   = '0;
                state_d = StBurst;
            end
            StBurst: begin
                bACCESS = 1'b1;
                bWRITE  = we_q;
                if (we_q) begin
                    wready_o[owner_q] = 1'b1;
                    bD                = wdata_i[owner_q*Width +: Width];
                end
                if (last_beat) begin
                    if (we_q) begin
                        done_o[owner_q] = 1'b1;
                        state_d         = StIdle;
                    end else begin
                        // Last read beat still has one cycle of latency.
                        state_d = StDrain;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                bWRITE          = we_q;
                done_o[owner_q] = 1'b1;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Read return path: bVALID is only meaningful during an owned read.
        if (!we_q && (state_q == StBurst || state_q == StDrain)) begin
            rvalid_o[owner_q] = bVALID;
            rdata_o           = bQ;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sbi_burst_arbiter.sv
module tb_sbi_burst_arbiter;

    localparam int unsigned NumReq = 2;
    localparam int unsigned Width  = 32;
    localparam int unsigned Depth  = 256;
    localparam int unsigned MaxLen = 16;
    localparam int unsigned Aw     = 8;
    localparam int unsigned Lw     = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b1;
    logic [NumReq-1:0]       req_i = '0;
    logic [NumReq-1:0]       we_i = '0;
    logic [NumReq*Aw-1:0]    addr_i = '0;
    logic [NumReq*Lw-1:0]    len_i = '0;
    logic [NumReq*Width-1:0] wdata_i;
    logic [NumReq-1:0]       gnt_o, wready_o, rvalid_o, done_o;
    logic [Width-1:0]        rdata_o;
    logic                    busy_o;
    logic [Aw-1:0]           bADDR;
    logic                    bSTART, bACCESS, bWRITE;
    logic [Width-1:0]        bD;
    logic [Width-1:0]        bQ = '0;
    logic                    bVALID = 1'b0;

    int checks = 0;
    int errors = 0;

    // Client-side write buffers, rewound on each grant.
    logic [Width-1:0] wbuf [NumReq][MaxLen];
    logic [Lw-1:0]    widx [NumReq];
    // SBI memory model: fixed 1-cycle read latency, address wraps at Depth.
    logic [Width-1:0] mem [Depth];
    logic [Aw-1:0]    mptr = '0;
    logic [Width-1:0] rq [$];

    sbi_burst_arbiter #(
        .NumReq (NumReq),
        .Width  (Width),
        .Depth  (Depth),
        .MaxLen (MaxLen)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .len_i    (len_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .wready_o (wready_o),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .bADDR    (bADDR),
        .bSTART   (bSTART),
        .bACCESS  (bACCESS),
        .bWRITE   (bWRITE),
        .bD       (bD),
        .bQ       (bQ),
        .bVALID   (bVALID)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            wdata_i[r*Width +: Width] = wbuf[r][widx[r]];
        end
    end

    always @(posedge clk_i) begin
        for (int r = 0; r < NumReq; r++) begin
            if (gnt_o[r]) widx[r] <= '0;
            else if (wready_o[r]) widx[r] <= widx[r] + 1'b1;
        end
    end

    always @(posedge clk_i) begin
        bVALID <= 1'b0;
        if (bSTART) mptr <= bADDR;
        if (bACCESS) begin
            if (bWRITE) begin
                mem[mptr] <= bD;
            end else begin
                bQ     <= mem[mptr];
                bVALID <= 1'b1;
            end
            mptr <= mptr + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int r, input bit we, input logic [Aw-1:0] addr,
                           input logic [Lw-1:0] len);
        we_i[r]              = we;
        addr_i[r*Aw +: Aw]   = addr;
        len_i[r*Lw +: Lw]    = len;
        req_i[r]             = 1'b1;
    endtask

    // Runs one burst to completion, collecting read beats into rq.
    task automatic run_burst(input int r, input bit we, input logic [Aw-1:0] addr,
                             input logic [Lw-1:0] len, output int acc, output int dones,
                             output bit tmo);
        int n;
        acc = 0;
        dones = 0;
        tmo = 1'b0;
        rq.delete();
        set_req(r, we, addr, len);
        #1;
        n = 0;
        while (!gnt_o[r] && n < 50) begin
            tick();
            n++;
        end
        if (!gnt_o[r]) begin
            tmo = 1'b1;
            req_i[r] = 1'b0;
            return;
        end
        tick();
        req_i[r] = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin
            if (bACCESS) acc++;
            if (done_o[r]) dones++;
            if (rvalid_o[r]) rq.push_back(rdata_o);
            tick();
            n++;
        end
        if (busy_o) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({gnt_o, wready_o, rvalid_o, done_o, busy_o, bSTART, bACCESS, bWRITE} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {gnt_o, wready_o, rvalid_o, done_o, busy_o, bSTART, bACCESS, bWRITE});
        end
        checks++;
        if ({bADDR, bD, rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0h expected 0", {bADDR, bD, rdata_o});
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        for (int k = 0; k < 4; k++) wbuf[0][k] = 32'hA0 + k;
        set_req(0, 1'b1, 8'h10, 4'd3);
        #1;
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL wr_gnt: got %b expected 01", gnt_o);
        end
        for (int c = 1; c <= 6; c++) begin
            logic exp_acc;
            tick();
            if (c == 1) req_i[0] = 1'b0;
            exp_acc = (c >= 2 && c <= 5);
            checks++;
            if ({bSTART, bACCESS, busy_o} !== {c == 1, exp_acc, c <= 5}) begin
                errors++;
                $display("FAIL wr_ctrl c%0d: got %b expected %b", c,
                         {bSTART, bACCESS, busy_o}, {c == 1, exp_acc, c <= 5});
            end
            checks++;
            if (bD !== (exp_acc ? 32'hA0 + c - 2 : 32'h0) || wready_o !== {1'b0, exp_acc}) begin
                errors++;
                $display("FAIL wr_data c%0d: got %0h/%b expected %0h/%b", c, bD, wready_o,
                         exp_acc ? 32'hA0 + c - 2 : 32'h0, {1'b0, exp_acc});
            end
            checks++;
            if (done_o !== ((c == 5) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL wr_done c%0d: got %b", c, done_o);
            end
            if (c == 1) begin
                checks++;
                if (bADDR !== 8'h10 || bWRITE !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_start: got %0h/%b expected 10/1", bADDR, bWRITE);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[8'h10 + k] !== 32'hA0 + k) begin
                errors++;
                $display("FAIL wr_mem %0d: got %0h expected %0h", k, mem[8'h10 + k], 32'hA0 + k);
            end
        end
    endtask

    task automatic test_single_read();
        set_req(1, 1'b0, 8'h10, 4'd3);
        #1;
        checks++;
        if (gnt_o !== 2'b10) begin
            errors++;
            $display("FAIL rd_gnt: got %b expected 10", gnt_o);
        end
        for (int c = 1; c <= 7; c++) begin
            logic [1:0] exp_rv;
            tick();
            if (c == 1) req_i[1] = 1'b0;
            exp_rv = (c >= 3 && c <= 6) ? 2'b10 : 2'b00;
            checks++;
            if ({bSTART, bACCESS, bWRITE, busy_o} !== {c == 1, c >= 2 && c <= 5, 1'b0, c <= 6}) begin
                errors++;
                $display("FAIL rd_ctrl c%0d: got %b", c, {bSTART, bACCESS, bWRITE, busy_o});
            end
            checks++;
            if (rvalid_o !== exp_rv || done_o !== ((c == 6) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL rd_valid c%0d: got %b/%b expected %b", c, rvalid_o, done_o, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rdata_o !== 32'hA0 + c - 3) begin
                    errors++;
                    $display("FAIL rd_data c%0d: got %0h expected %0h", c, rdata_o,
                             32'hA0 + c - 3);
                end
            end
        end
    endtask

    task automatic test_contention();
        int order [4];
        int ng, n, overlap;
        ng = 0;
        n = 0;
        overlap = 0;
        set_req(0, 1'b1, 8'h20, 4'd0);
        set_req(1, 1'b1, 8'h30, 4'd0);
        #1;
        while (ng < 4 && n < 60) begin
            if (bSTART && bACCESS) overlap++;
            if (gnt_o != 2'b00) begin
                order[ng] = gnt_o[1] ? 1 : 0;
                ng++;
            end
            tick();
            if (ng == 4) req_i = '0;
            n++;
        end
        n = 0;
        while (busy_o && n < 20) begin
            if (bSTART && bACCESS) overlap++;
            tick();
            n++;
        end
        checks++;
        if (ng != 4 || busy_o) begin
            errors++;
            $display("FAIL cont_count: got %0d grants busy=%b expected 4 idle", ng, busy_o);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (order[i] != i % 2) begin
                errors++;
                $display("FAIL cont_order %0d: got %0d expected %0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL cont_overlap: got %0d expected 0", overlap);
        end
    endtask

    task automatic test_wrap();
        int acc, dones;
        bit tmo;
        logic [Aw-1:0] a;
        for (int k = 0; k < 4; k++) wbuf[0][k] = 32'hB0 + k;
        run_burst(0, 1'b1, 8'hFE, 4'd3, acc, dones, tmo);
        checks++;
        if (tmo || acc != 4 || dones != 1) begin
            errors++;
            $display("FAIL wrap_wr: got tmo=%b acc=%0d done=%0d expected 0/4/1", tmo, acc, dones);
        end
        for (int k = 0; k < 4; k++) begin
            a = 8'hFE + 8'(k);
            checks++;
            if (mem[a] !== 32'hB0 + k) begin
                errors++;
                $display("FAIL wrap_mem %0h: got %0h expected %0h", a, mem[a], 32'hB0 + k);
            end
        end
        run_burst(1, 1'b0, 8'hFE, 4'd3, acc, dones, tmo);
        checks++;
        if (tmo || rq.size() != 4 || dones != 1) begin
            errors++;
            $display("FAIL wrap_rd: got tmo=%b beats=%0d done=%0d expected 0/4/1", tmo,
                     rq.size(), dones);
        end
        for (int k = 0; k < rq.size() && k < 4; k++) begin
            checks++;
            if (rq[k] !== 32'hB0 + k) begin
                errors++;
                $display("FAIL wrap_rdata %0d: got %0h expected %0h", k, rq[k], 32'hB0 + k);
            end
        end
    endtask

    task automatic test_max_len();
        int acc, dones;
        bit tmo;
        for (int k = 0; k < 16; k++) wbuf[0][k] = 32'hC0 + k;
        run_burst(0, 1'b1, 8'h40, 4'd15, acc, dones, tmo);
        checks++;
        if (tmo || acc != 16 || dones != 1) begin
            errors++;
            $display("FAIL max_wr: got tmo=%b acc=%0d done=%0d expected 0/16/1", tmo, acc, dones);
        end
        checks++;
        if (mem[8'h40] !== 32'hC0 || mem[8'h4F] !== 32'hCF) begin
            errors++;
            $display("FAIL max_mem: got %0h..%0h expected c0..cf", mem[8'h40], mem[8'h4F]);
        end
        run_burst(1, 1'b0, 8'h40, 4'd15, acc, dones, tmo);
        checks++;
        if (tmo || acc != 16 || rq.size() != 16 || dones != 1) begin
            errors++;
            $display("FAIL max_rd: got tmo=%b acc=%0d beats=%0d done=%0d expected 0/16/16/1",
                     tmo, acc, rq.size(), dones);
        end
        checks++;
        if (rq.size() != 16 || rq[15] !== 32'hCF) begin
            errors++;
            $display("FAIL max_rdata: got beats=%0d expected last cf", rq.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        set_req(1, 1'b0, 8'h40, 4'd7);
        #1;
        n = 0;
        while (!gnt_o[1] && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_i = '0;
        tick();
        tick();
        checks++;
        if (bACCESS !== 1'b1 || rvalid_o !== 2'b10) begin
            errors++;
            $display("FAIL mid_beat2: got acc=%b rv=%b expected 1/10", bACCESS, rvalid_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({gnt_o, wready_o, rvalid_o, done_o, busy_o, bSTART, bACCESS, bWRITE} !== '0) begin
            errors++;
            $display("FAIL mid_ctrl: got %b expected 0",
                     {gnt_o, wready_o, rvalid_o, done_o, busy_o, bSTART, bACCESS, bWRITE});
        end
        checks++;
        if ({bADDR, bD, rdata_o} !== '0) begin
            errors++;
            $display("FAIL mid_data: got %0h expected 0", {bADDR, bD, rdata_o});
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        set_req(0, 1'b1, 8'h60, 4'd0);
        set_req(1, 1'b1, 8'h70, 4'd0);
        #1;
        checks++;
        if (gnt_o !== 2'b01 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_regrant: got %b busy=%b expected 01 idle", gnt_o, busy_o);
        end
        tick();
        req_i = '0;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_finish: got busy=%b expected 0", busy_o);
        end
    endtask

    initial begin
        for (int r = 0; r < NumReq; r++) begin
            widx[r] = '0;
            for (int k = 0; k < MaxLen; k++) wbuf[r][k] = '0;
        end
        #2;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_wrap();
        test_max_len();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
